// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
package mips_mem_pkg;

    localparam int WAIT_W   = 4;
    localparam int WAIT_MIN = 1;
    localparam int WAIT_MAX = 15;

    typedef enum logic [2:0] {
        IDLE,
        IF_ACC,
        D_ACC,
        IF_RESP,
        D_RESP
    } arb_state_t;

    typedef enum logic {
        FETCH,
        DATA
    } gnt_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Request/response and memory-side bus of the memory port arbiter.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 30,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_valid;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [3:0]        d_be;
    logic [DATA_W-1:0] d_rdata;
    logic              d_valid;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [3:0]        mem_be;
    logic [DATA_W-1:0] mem_rdata;

    logic              stall;

    // Arbiter side.
    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_rdata,
        output if_rdata, if_valid, d_rdata, d_valid,
               mem_en, mem_we, mem_addr, mem_wdata, mem_be, stall
    );

    // Pipeline and memory side.
    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_rdata,
        input  if_rdata, if_valid, d_rdata, d_valid,
               mem_en, mem_we, mem_addr, mem_wdata, mem_be, stall
    );

endinterface

// File: rtl/mem_port_arbiter_wait_counter.sv
// Loadable down-counter timing the fixed-latency memory access.
module arb_wait_counter
    import mips_mem_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [WAIT_W-1:0] load_val,
    input  logic              en,
    output logic              last
);

    logic [WAIT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign last = (count == WAIT_W'(1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store.
// Optional single-entry fetch buffer enabled by defining ARB_FETCH_BUF_EN.
module mem_port_arbiter
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W      = 30,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 1
)
(
    input  logic             clk,
    input  logic             rst_n,
    mem_port_arbiter_if.slave bus
);

    if ((WAIT_CYCLES < WAIT_MIN) || (WAIT_CYCLES > WAIT_MAX)) begin : g_bad_wait
        $error("mem_port_arbiter: WAIT_CYCLES must be within 1..15");
    end

    localparam logic [WAIT_W-1:0] WAIT_LD = WAIT_W'(WAIT_CYCLES);

    arb_state_t        state_q;
    gnt_t              last_gnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [3:0]        be_q;
    logic              we_q;
    logic              mem_en_q;
    logic              mem_we_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;
    logic              if_valid_q;
    logic              d_valid_q;

    logic              d_wins;
    logic              grant_d;
    logic              grant_f;
    logic              fetch_hit;
    logic [DATA_W-1:0] hit_data;
    logic              cnt_load;
    logic              cnt_en;
    logic              cnt_last;

    // Data normally wins; fetch takes the turn right after a data grant.
    assign d_wins  = bus.d_req && !((last_gnt_q == DATA) && bus.if_req);
    assign grant_d = (state_q == IDLE) && d_wins;
    assign grant_f = (state_q == IDLE) && bus.if_req && !d_wins;

    assign cnt_load = grant_d || (grant_f && !fetch_hit);
    assign cnt_en   = (state_q == IF_ACC) || (state_q == D_ACC);

    arb_wait_counter u_wait (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (WAIT_LD),
        .en       (cnt_en),
        .last     (cnt_last)
    );

`ifdef ARB_FETCH_BUF_EN
    logic [ADDR_W-1:0] buf_addr;
    logic [DATA_W-1:0] buf_data;
    logic              buf_valid;

    assign fetch_hit = buf_valid && (bus.if_addr == buf_addr);
    assign hit_data  = buf_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_valid <= 1'b0;
            buf_addr  <= '0;
            buf_data  <= '0;
        end else if ((state_q == IF_ACC) && cnt_last) begin
            buf_valid <= 1'b1;
            buf_addr  <= addr_q;
            buf_data  <= bus.mem_rdata;
        end else if (grant_d && bus.d_we && (bus.d_addr == buf_addr)) begin
            buf_valid <= 1'b0;
        end
    end
`else
    assign fetch_hit = 1'b0;
    assign hit_data  = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            last_gnt_q <= FETCH;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            we_q       <= 1'b0;
            mem_en_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
            if_valid_q <= 1'b0;
            d_valid_q  <= 1'b0;
        end else begin
            if_valid_q <= 1'b0;
            d_valid_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_d) begin
                        state_q  <= D_ACC;
                        addr_q   <= bus.d_addr;
                        wdata_q  <= bus.d_wdata;
                        be_q     <= bus.d_we ? bus.d_be : 4'b0000;
                        we_q     <= bus.d_we;
                        mem_en_q <= 1'b1;
                        mem_we_q <= bus.d_we;
                    end else if (grant_f) begin
                        if (fetch_hit) begin
                            state_q    <= IF_RESP;
                            if_rdata_q <= hit_data;
                            if_valid_q <= 1'b1;
                        end else begin
                            state_q  <= IF_ACC;
                            addr_q   <= bus.if_addr;
                            be_q     <= '0;
                            we_q     <= 1'b0;
                            mem_en_q <= 1'b1;
                            mem_we_q <= 1'b0;
                        end
                    end
                end
                IF_ACC: begin
                    if (cnt_last) begin
                        state_q    <= IF_RESP;
                        if_rdata_q <= bus.mem_rdata;
                        if_valid_q <= 1'b1;
                        mem_en_q   <= 1'b0;
                    end
                end
                D_ACC: begin
                    if (cnt_last) begin
                        state_q   <= D_RESP;
                        if (!we_q) begin
                            d_rdata_q <= bus.mem_rdata;
                        end
                        d_valid_q <= 1'b1;
                        mem_en_q  <= 1'b0;
                        mem_we_q  <= 1'b0;
                        be_q      <= '0;
                    end
                end
                IF_RESP: begin
                    last_gnt_q <= FETCH;
                    state_q    <= IDLE;
                end
                D_RESP: begin
                    last_gnt_q <= DATA;
                    state_q    <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_be    = be_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.if_valid  = if_valid_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.d_valid   = d_valid_q;
    assign bus.stall     = (bus.if_req & ~if_valid_q) | (bus.d_req & ~d_valid_q);

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-port word-addressed memory between the MIPS instruction-fetch path and the load/store data path. Each side presents a hold-until-valid request; the arbiter serialises them, sequences the fixed-latency memory access, and returns read data with a one-cycle valid pulse. It drives a combinational `stall` that freezes the PC and register-file write while any request is outstanding.

## Interface
- `ADDR_W`, 30: word-address width, matching byte address [31:2].
- `DATA_W`, 32: data width.
- `WAIT_CYCLES`, 1: memory access cycles per transfer. Legal range 1..15; any other value is an elaboration error.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `if_req` input 1: fetch request, held until `if_valid`.
- `if_addr` input ADDR_W: fetch word address, stable while `if_req`.
- `if_rdata` output DATA_W: fetched instruction, held until the next fetch completes.
- `if_valid` output 1: one-cycle completion pulse for fetch.
- `d_req` input 1: data request, held until `d_valid`.
- `d_we` input 1: 1 means store, 0 means load.
- `d_addr` input ADDR_W: data word address.
- `d_wdata` input DATA_W: store data.
- `d_be` input 4: store byte enables.
- `d_rdata` output DATA_W: load data, held until the next load completes.
- `d_valid` output 1: one-cycle completion pulse for load or store.
- `mem_en`, `mem_we` output 1: memory enable and write strobe.
- `mem_addr` output ADDR_W, `mem_wdata` output DATA_W, `mem_be` output 4: memory address, write data and byte enables.
- `mem_rdata` input DATA_W: memory read data, valid in the last ACC cycle.
- `stall` output 1: equals `(if_req & ~if_valid) | (d_req & ~d_valid)`. Combinational.

## Operation
- States: IDLE, IF_ACC, D_ACC, IF_RESP, D_RESP.
- IDLE, arbitration on the clock edge:
  - A request that is high in IDLE is a new request.
  - If both are requesting, data wins, unless `last_gnt` is DATA and `if_req` is high; then fetch wins. This prevents starvation.
  - The winner's address, write data, byte enables and we are registered. The wait counter loads WAIT_CYCLES.
- IF_ACC and D_ACC:
  - `mem_en`=1 and the registered address is driven.
  - `mem_we`=`d_we` only in D_ACC. `mem_we` is always 0 for fetch.
  - The counter decrements every cycle.
  - When counter==1, the next edge captures `mem_rdata` into `if_rdata` or `d_rdata` (loads only) and moves to the matching RESP state.
- IF_RESP and D_RESP:
  - The matching valid is 1 for exactly one cycle. `last_gnt` is updated.
  - Next state is always IDLE.
- A store may be sampled by the memory on every ACC edge. This is idempotent. `d_rdata` is unchanged by stores.
- A request dropped before its valid pulse is protocol misuse. The access still completes and the valid pulse is still issued.

## Timing
- Request sampled at edge k in IDLE: ACC lasts cycles k+1..k+WAIT_CYCLES; valid is high in cycle k+WAIT_CYCLES+1.
- Latency is WAIT_CYCLES+1 cycles. Peak throughput is one access per WAIT_CYCLES+2 cycles.
- If both requests arrive together, the loser's valid follows the winner's by WAIT_CYCLES+2 cycles.
- Reset values:
  - State IDLE, counter 0, `last_gnt` FETCH.
  - All valids, `mem_en` and `mem_we` are 0.
  - `mem_addr`, `mem_wdata`, `mem_be`, `if_rdata` and `d_rdata` are 0.
- Reset asserted mid-access:
  - `mem_we` and `mem_en` drop immediately (asynchronous). The access is abandoned with no valid pulse.
  - An abandoned store's memory effect is undefined.

## Configuration
- `ARB_FETCH_BUF_EN` defined:
  - Adds a single-entry fetch buffer: `buf_addr`, `buf_data`, `buf_valid`. It is filled on every completed fetch.
  - Fetch hit: in IDLE, fetch wins arbitration and `if_addr`==`buf_addr` with `buf_valid`. The next state is IF_RESP directly, so latency is 1 cycle with no memory access. `if_rdata` takes `buf_data`.
  - Invalidation: a granted store whose address equals `buf_addr` clears `buf_valid`, at grant.
  - Reset clears `buf_valid`.
- `ARB_FETCH_BUF_EN` undefined: no buffer logic. Every fetch goes to memory.

## Structure
- Package `mips_mem_pkg` holds:
  - `arb_state_t` enum (5 states);
  - `gnt_t` enum {FETCH, DATA};
  - `WAIT_W`=4;
  - `WAIT_MIN`=1 and `WAIT_MAX`=15.
- One sub-module, `arb_wait_counter`:
  - loadable 4-bit down-counter;
  - inputs: load, load value, enable;
  - output: `last` flag, high at count==1.
- Arbitration, the state machine and the optional buffer live in the top module.

## Test plan
- Reset, then with WAIT_CYCLES=2, `if_req` with `if_addr`=0x10 and memory word 0x2402_0005 → `mem_en` high for 2 cycles, then `if_valid` pulses in cycle 3 with `if_rdata`=0x2402_0005. `stall` is high until then.
- Simultaneous `if_req` (addr 0x4) and load `d_req` (addr 0x20, data 0xDEAD_BEEF), `last_gnt`=FETCH → `d_valid` in cycle 3 with 0xDEAD_BEEF; `if_valid` in cycle 7.
- Back-to-back loads with `if_req` held → after a data grant, the next grant goes to fetch. Order is D, F, D.
- Store `d_addr`=0x8, wdata 0x1234_5678, `d_be`=4'b0011 → `mem_we`/`mem_be` asserted only during D_ACC. `d_valid` pulses and `d_rdata` is unchanged. A following load of 0x8 returns the memory's merged word.
- `rst_n` dropped in the first D_ACC cycle of a store → `mem_we`=0 in the same cycle. No `d_valid`. Outputs take reset values and the block restarts in IDLE.
- With `ARB_FETCH_BUF_EN`: fetch 0x10 twice → second fetch `if_valid` after 1 cycle with no `mem_en`. Then store to 0x10 and fetch 0x10 again → a full memory access occurs.
